// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults, bank encoding and address split helpers
//                for the banked register file.
//  Revision    : 1.0
// ============================================================================
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  typedef enum logic {
    BANK_GPR = 1'b0,
    BANK_CTL = 1'b1
  } bank_e;

  // Address layout is {bank, index}; the bank bit sits just above the index.
  function automatic bank_e addr_bank(input logic [31:0] addr, input int aw);
    return bank_e'(addr[aw[4:0]]);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int aw);
    return addr & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/psr_stack.sv
`default_nettype none
// ============================================================================
//  Module      : psr_stack
//  Description : Saturating LIFO of saved PSR values with sticky
//                overflow / underflow flags.
//  Revision    : 1.0
// ============================================================================
module psr_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_unf;

  logic              w_do_push;
  logic              w_do_pop;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_wr_idx;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_top_idx = IDX_W'(r_count - CNT_W'(1));
  assign w_wr_idx  = IDX_W'(r_count);
  assign dout      = empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

  // Simultaneous push and pop cancel out and raise no error.
  assign w_do_push = push && !pop && !full;
  assign w_do_pop  = pop && !push && !empty;
  assign w_set_ovf = push && !pop && full;
  assign w_set_unf = pop && !push && empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[w_wr_idx] <= din;
        r_count         <= r_count + CNT_W'(1);
      end else if (w_do_pop) begin
        r_count <= r_count - CNT_W'(1);
      end

      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end else if (err_clr) begin
        r_ovf <= 1'b0;
      end

      if (w_set_unf) begin
        r_unf <= 1'b1;
      end else if (err_clr) begin
        r_unf <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/banked_regfile_psrstack.sv
`default_nettype none
// ============================================================================
//  Module      : banked_regfile_psrstack
//  Description : Two-bank register file (general + control) with two read
//                ports, prioritised dual write, optional bypass and a PSR
//                save stack for nested traps.
//  Revision    : 1.0
// ============================================================================
module banked_regfile_psrstack
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int PSR_DEPTH = 4,
  parameter int BYPASS    = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [REG_AW:0]                ra1,
  input  logic [REG_AW:0]                ra2,
  output logic [DATA_W-1:0]              rd1,
  output logic [DATA_W-1:0]              rd2,
  input  logic [REG_AW:0]                wa_a,
  input  logic [REG_AW:0]                wa_b,
  input  logic [DATA_W-1:0]              wd_a,
  input  logic [DATA_W-1:0]              wd_b,
  input  logic                           we_a,
  input  logic                           we_b,
  input  logic [DATA_W-1:0]              psr_in,
  input  logic                           psr_we,
  input  logic                           psr_push,
  input  logic                           psr_pop,
  input  logic                           err_clr,
  output logic [DATA_W-1:0]              psr_out,
  output logic [$clog2(PSR_DEPTH+1)-1:0] stk_count,
  output logic                           stk_full,
  output logic                           stk_empty,
  output logic                           stk_ovf,
  output logic                           stk_unf
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] r_gpr [NREG];
  logic [DATA_W-1:0] r_ctl [NREG];
  logic [DATA_W-1:0] r_psr;

  logic [REG_AW-1:0] w_idx_a;
  logic [REG_AW-1:0] w_idx_b;
  bank_e             w_bank_a;
  bank_e             w_bank_b;
  logic              w_wr_a;
  logic              w_wr_b;
  logic [DATA_W-1:0] w_stk_top;

  assign w_idx_a  = REG_AW'(addr_index(32'(wa_a), REG_AW));
  assign w_idx_b  = REG_AW'(addr_index(32'(wa_b), REG_AW));
  assign w_bank_a = addr_bank(32'(wa_a), REG_AW);
  assign w_bank_b = addr_bank(32'(wa_b), REG_AW);

  // Port B loses to port A on an address collision; index 0 is never written.
  assign w_wr_a = we_a && (w_idx_a != '0);
  assign w_wr_b = we_b && (w_idx_b != '0) && !(we_a && (wa_a == wa_b));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_gpr[i] <= '0;
        r_ctl[i] <= '0;
      end
    end else begin
      if (w_wr_a) begin
        if (w_bank_a == BANK_CTL) r_ctl[w_idx_a] <= wd_a;
        else                      r_gpr[w_idx_a] <= wd_a;
      end
      if (w_wr_b) begin
        if (w_bank_b == BANK_CTL) r_ctl[w_idx_b] <= wd_b;
        else                      r_gpr[w_idx_b] <= wd_b;
      end
    end
  end

  logic [1:0][REG_AW:0]   w_ra;
  logic [1:0][DATA_W-1:0] w_rd;

  assign w_ra = {ra2, ra1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [REG_AW-1:0] w_idx;
    bank_e             w_bank;
    logic [DATA_W-1:0] w_stored;
    logic              w_hit_a;
    logic              w_hit_b;

    assign w_idx    = REG_AW'(addr_index(32'(w_ra[p]), REG_AW));
    assign w_bank   = addr_bank(32'(w_ra[p]), REG_AW);
    assign w_stored = (w_idx == '0)         ? '0 :
                      (w_bank == BANK_CTL)  ? r_ctl[w_idx] : r_gpr[w_idx];
    assign w_hit_a  = (BYPASS != 0) && w_wr_a && (wa_a == w_ra[p]);
    assign w_hit_b  = (BYPASS != 0) && w_wr_b && (wa_b == w_ra[p]);
    assign w_rd[p]  = w_hit_a ? wd_a : (w_hit_b ? wd_b : w_stored);
  end

  assign rd1 = w_rd[0];
  assign rd2 = w_rd[1];

  psr_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (PSR_DEPTH)
  ) u_psr_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (psr_push),
    .pop     (psr_pop),
    .err_clr (err_clr),
    .din     (r_psr),
    .dout    (w_stk_top),
    .count   (stk_count),
    .full    (stk_full),
    .empty   (stk_empty),
    .ovf     (stk_ovf),
    .unf     (stk_unf)
  );

  // A successful pop restores the saved PSR and overrides psr_we.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_psr <= '0;
    end else if (psr_pop && !psr_push && !stk_empty) begin
      r_psr <= w_stk_top;
    end else if (psr_we) begin
      r_psr <= psr_in;
    end
  end

  assign psr_out = r_psr;

endmodule
`default_nettype wire

// File: doc/banked_regfile_psrstack.md
# banked_regfile_psrstack

Parametrised two-bank register file (general bank + control bank) with two read ports, two prioritised write ports, optional write-to-read bypass, and a hardware PSR save stack for nested traps. Sits in the decode/writeback stage of the processor core, replacing the fixed 16-bit, 8-entry control-and-general register file. It adds configurable width and depth, same-cycle bypass, and push/pop PSR save/restore with overflow and underflow detection.

## Interface
Parameters:
- DATA_W, 16, register and PSR width
- REG_AW, 3, register index bits per bank (2^REG_AW entries per bank; index 0 of each bank is hardwired zero)
- PSR_DEPTH, 4, PSR stack entries (≥2)
- BYPASS, 1, 1 = a read of a register being written returns the write data in the same cycle

Ports (address = {bank, index}; bank 0 = general, 1 = control):
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ra1, ra2  in  REG_AW+1  read addresses
- rd1, rd2  out  DATA_W  read data (combinational)
- wa_a, wa_b  in  REG_AW+1  write addresses, ports A and B
- wd_a, wd_b  in  DATA_W  write data
- we_a, we_b  in  1  write enables
- psr_in  in  DATA_W  new PSR value
- psr_we  in  1  load psr_in into the current PSR
- psr_push  in  1  save the current PSR to the stack (trap entry)
- psr_pop  in  1  restore the current PSR from the stack top (return from trap)
- err_clr  in  1  clear the sticky error flags
- psr_out  out  DATA_W  current PSR
- stk_count  out  $clog2(PSR_DEPTH+1)  number of valid stack entries
- stk_full, stk_empty  out  1  stack status
- stk_ovf, stk_unf  out  1  sticky overflow / underflow

## Operation
- Reads: index 0 returns 0 in either bank. Otherwise the addressed bank entry is returned.
- If BYPASS=1, a read matching an enabled write address returns the write data (port A data if both ports match). If BYPASS=0, a read returns the stored value.
- Writes to index 0 are ignored.
- we_a and we_b with equal wa_a and wa_b: port A is written and port B is dropped. Different addresses: both are written.
- PSR update, in priority order per cycle:
  - psr_push & psr_pop together: no stack change; psr_we still applies; stk_ovf and stk_unf are untouched.
  - psr_pop with stk_empty=0: psr_out ← top entry, count−1, psr_we ignored.
  - psr_pop with stk_empty=1: stk_unf ← 1; PSR follows psr_we.
  - psr_push with stk_full=0: stack top ← current psr_out, count+1; psr_out ← psr_in if psr_we, else unchanged.
  - psr_push with stk_full=1: stack unchanged, stk_ovf ← 1; psr_we still applies.
  - otherwise psr_we loads psr_in.
- err_clr clears stk_ovf and stk_unf. If a new error occurs in the same cycle, the set wins.
- stk_full = (count==PSR_DEPTH); stk_empty = (count==0).

## Timing
- Reset (reset_n low, asynchronous) sets all registers, the current PSR, every stack entry, count, and both flags to 0. Outputs after reset: rd1/rd2 = 0, psr_out = 0, stk_count = 0, stk_empty = 1, stk_full = 0, stk_ovf = stk_unf = 0.
- Deassertion is sampled synchronously by the surrounding design. Reset asserted mid-trap discards all stack contents.
- Writes and PSR/stack updates take effect at the rising edge of clk. Results are visible on rd*/psr_out and the stack status outputs after that edge (0-cycle read latency).
- With BYPASS=1, rd* reflects wd_* in the same cycle as the write (combinational path from wd to rd).
- Pop followed by push in consecutive cycles is legal at full throughput. Stack pointer arithmetic is saturating and never wraps.

## Structure
- Package regfile_pkg holds:
  - DATA_W and REG_AW defaults
  - bank encodings (BANK_GPR=0, BANK_CTL=1)
  - the function splitting an address into {bank, index}
- Sub-module psr_stack holds:
  - the LIFO storage, count, full/empty logic and sticky flags
  - inputs push/pop/din/err_clr; outputs dout/count/full/empty/ovf/unf
- The top module instantiates psr_stack and contains the two bank arrays, the write arbitration, and the bypass muxes.

## Test plan
- Reset, then write 0x1234 to {0,3} and 0xBEEF to {1,3}, then read both → rd1 = 0x1234, rd2 = 0xBEEF. Write 0xFFFF to {0,0} → reads 0.
- we_a/we_b to {1,5} with 0xAAAA/0x5555 → 0xAAAA stored. Read {1,5} the same cycle with BYPASS=1 → 0xAAAA. With BYPASS=0 → the old value.
- Load PSR 0x0011, then push with psr_in 0x0022 → psr_out 0x0022, count 1. Pop → psr_out 0x0011, count 0, stk_empty 1.
- Push 5 times with PSR_DEPTH=4 → count 4, stk_full 1, stk_ovf set on the 5th push. Pop 4 times to recover the saved values in LIFO order. A 5th pop sets stk_unf. err_clr clears both flags.
- Push & pop in the same cycle with psr_we and psr_in 0x0077 → count unchanged, psr_out 0x0077, no flags set.
- Drop reset_n mid-sequence (count 2, regs nonzero) between clock edges → all outputs are 0 and stk_empty is 1 immediately, without waiting for a clock edge.
